ex_stage: RTL and testbench

Execute stage of the rv32i pipeline. Consumes the ID/EX register outputs, resolves operand forwarding from MEM and WB, computes the ALU result, resolves branches and jumps, and drives the redirect. Shifts run on an iterative one-bit-per-cycle shifter. While a shift is in progress the block raises `ex_busy`, which holds IF/ID and ID/EX and inserts bubbles into EX/MEM.

---
 rtl/rv32i_pkg.sv | 57 +++++
 rtl/ex_shift_serial.sv | 93 +++++++++
 rtl/ex_stage.sv | 128 ++++++++++++
 tb/tb_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - rv32i shared encodings: ALU/branch codes, opcodes, shift FSM states
package rv32i_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] BU_BEQ  = 3'b000;
    localparam logic [2:0] BU_BNE  = 3'b001;
    localparam logic [2:0] BU_BLT  = 3'b100;
    localparam logic [2:0] BU_BGE  = 3'b101;
    localparam logic [2:0] BU_BLTU = 3'b110;
    localparam logic [2:0] BU_BGEU = 3'b111;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_DONE  = 2'd2
    } shift_state_t;

    function automatic logic is_shift_func(input logic [3:0] func);
        return (func == ALU_SLL) || (func == ALU_SRL) || (func == ALU_SRA);
    endfunction

    // MEM beats WB; x0 always reads the register file.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  raddr,
        input logic [31:0] rf_data,
        input logic        mem_we,
        input logic [4:0]  mem_waddr,
        input logic [31:0] mem_data,
        input logic        wb_we,
        input logic [4:0]  wb_waddr,
        input logic [31:0] wb_data
    );
        if (raddr == 5'd0)
            return rf_data;
        if (mem_we && (mem_waddr == raddr))
            return mem_data;
        if (wb_we && (wb_waddr == raddr))
            return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/ex_shift_serial.sv
// rtl/ex_shift_serial.sv - iterative one-bit-per-cycle shifter with IDLE/SHIFT/DONE control
module ex_shift_serial
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  i_func,
    input  logic [31:0] i_a,
    input  logic [4:0]  i_shamt,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_done,
    output logic [31:0] o_result
);

    shift_state_t r_state;
    shift_state_t w_next;
    logic [31:0]  r_acc;
    logic [4:0]   r_cnt;
    logic [3:0]   r_func;
    logic         w_start;
    logic [31:0]  w_acc_shifted;

    assign w_start = is_shift_func(i_func) && (i_shamt != 5'd0);

    always_comb begin
        w_acc_shifted = r_acc;
        case (r_func)
            ALU_SLL: w_acc_shifted = {r_acc[30:0], 1'b0};
            ALU_SRL: w_acc_shifted = {1'b0, r_acc[31:1]};
            ALU_SRA: w_acc_shifted = {r_acc[31], r_acc[31:1]};
            default: w_acc_shifted = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= SH_IDLE;
            r_acc   <= 32'd0;
            r_cnt   <= 5'd0;
            r_func  <= ALU_ADD;
        end else begin
            r_state <= w_next;
            case (r_state)
                SH_IDLE: begin
                    if (w_start) begin
                        r_acc  <= i_a;
                        r_cnt  <= i_shamt;
                        r_func <= i_func;
                    end
                end
                SH_SHIFT: begin
                    r_acc <= w_acc_shifted;
                    r_cnt <= r_cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next  = r_state;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            SH_IDLE: begin
                if (w_start) begin
                    o_busy = 1'b1;
                    w_next = SH_SHIFT;
                end else begin
                    o_valid = 1'b1;
                end
            end
            SH_SHIFT: begin
                o_busy = 1'b1;
                if (r_cnt == 5'd1)
                    w_next = SH_DONE;
            end
            SH_DONE: begin
                o_valid = 1'b1;
                w_next  = SH_IDLE;
            end
            default: w_next = SH_IDLE;
        endcase
        // The stall must drop during reset so the held instruction is released.
        if (!rstn)
            o_busy = 1'b0;
    end

    assign o_done   = (r_state == SH_DONE);
    assign o_result = r_acc;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - rv32i execute stage: forwarding, ALU, branch unit, shifter (EX_FAST_SHIFT_EN selects barrel shifter)
module ex_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_ex_pc_current,
    input  logic [31:0] i_ex_immediate,
    input  logic        i_ex_alu_din_a_sel,
    input  logic        i_ex_alu_din_b_sel,
    input  logic [3:0]  i_ex_alu_func,
    input  logic [2:0]  i_ex_bu_func,
    input  logic [6:0]  i_ex_opcode,
    input  logic [31:0] i_ex_rf_dout_rs1,
    input  logic [31:0] i_ex_rf_dout_rs2,
    input  logic [4:0]  i_ex_rf_raddr_rs1,
    input  logic [4:0]  i_ex_rf_raddr_rs2,
    input  logic        i_mem_rf_we,
    input  logic [4:0]  i_mem_rf_waddr,
    input  logic [31:0] i_mem_fwd_data,
    input  logic        i_wb_rf_we,
    input  logic [4:0]  i_wb_rf_waddr,
    input  logic [31:0] i_wb_rf_din,
    output logic [31:0] o_ex_alu_result,
    output logic [31:0] o_ex_rs2_fwd,
    output logic        o_ex_valid,
    output logic        o_ex_busy,
    output logic        o_ex_branch_taken,
    output logic [31:0] o_ex_branch_target
);

    logic [31:0] w_rs1_fwd;
    logic [31:0] w_rs2_fwd;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic        w_cond;
    logic        w_taken;
    logic        w_valid;

    assign w_rs1_fwd = fwd_select(i_ex_rf_raddr_rs1, i_ex_rf_dout_rs1, i_mem_rf_we, i_mem_rf_waddr,
                                  i_mem_fwd_data, i_wb_rf_we, i_wb_rf_waddr, i_wb_rf_din);
    assign w_rs2_fwd = fwd_select(i_ex_rf_raddr_rs2, i_ex_rf_dout_rs2, i_mem_rf_we, i_mem_rf_waddr,
                                  i_mem_fwd_data, i_wb_rf_we, i_wb_rf_waddr, i_wb_rf_din);

    assign w_a     = i_ex_alu_din_a_sel ? i_ex_pc_current : w_rs1_fwd;
    assign w_b     = i_ex_alu_din_b_sel ? i_ex_immediate  : w_rs2_fwd;
    assign w_shamt = w_b[4:0];

    always_comb begin
        w_alu = 32'd0;
        case (i_ex_alu_func)
            ALU_ADD:   w_alu = w_a + w_b;
            ALU_SUB:   w_alu = w_a - w_b;
            ALU_SLT:   w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU:  w_alu = {31'd0, w_a < w_b};
            ALU_XOR:   w_alu = w_a ^ w_b;
            ALU_OR:    w_alu = w_a | w_b;
            ALU_AND:   w_alu = w_a & w_b;
            ALU_PASSB: w_alu = w_b;
`ifdef EX_FAST_SHIFT_EN
            ALU_SLL:   w_alu = w_a << w_shamt;
            ALU_SRL:   w_alu = w_a >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_a) >>> w_shamt);
`else
            // Only the shamt-0 case resolves combinationally; others finish in the serial shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = w_a;
`endif
            default:   w_alu = 32'd0;
        endcase
    end

`ifdef EX_FAST_SHIFT_EN
    assign o_ex_alu_result = w_alu;
    assign o_ex_busy       = 1'b0;
    assign w_valid         = 1'b1;
`else
    logic        w_sh_done;
    logic [31:0] w_sh_result;

    ex_shift_serial u_shift (
        .clk      (clk),
        .rstn     (rstn),
        .i_func   (i_ex_alu_func),
        .i_a      (w_a),
        .i_shamt  (w_shamt),
        .o_busy   (o_ex_busy),
        .o_valid  (w_valid),
        .o_done   (w_sh_done),
        .o_result (w_sh_result)
    );

    assign o_ex_alu_result = w_sh_done ? w_sh_result : w_alu;
`endif

    always_comb begin
        w_cond = 1'b0;
        case (i_ex_bu_func)
            BU_BEQ:  w_cond = (w_rs1_fwd == w_rs2_fwd);
            BU_BNE:  w_cond = (w_rs1_fwd != w_rs2_fwd);
            BU_BLT:  w_cond = ($signed(w_rs1_fwd) <  $signed(w_rs2_fwd));
            BU_BGE:  w_cond = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
            BU_BLTU: w_cond = (w_rs1_fwd <  w_rs2_fwd);
            BU_BGEU: w_cond = (w_rs1_fwd >= w_rs2_fwd);
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken            = 1'b0;
        o_ex_branch_target = i_ex_pc_current + i_ex_immediate;
        case (i_ex_opcode)
            OPC_BRANCH: w_taken = w_cond;
            OPC_JAL:    w_taken = 1'b1;
            OPC_JALR: begin
                w_taken            = 1'b1;
                o_ex_branch_target = (w_rs1_fwd + i_ex_immediate) & ~32'd1;
            end
            default:    w_taken = 1'b0;
        endcase
    end

    assign o_ex_valid        = w_valid;
    assign o_ex_branch_taken = w_taken && w_valid;
    assign o_ex_rs2_fwd      = w_rs2_fwd;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc, imm, rf1, rf2, mfd, wdin;
    logic        asel, bsel, mwe, wwe;
    logic [3:0]  func;
    logic [2:0]  bu;
    logic [6:0]  opc;
    logic [4:0]  ra1, ra2, mwa, wwa;
    logic [31:0] res, rs2f, tgt;
    logic        valid, busy, taken;

    int total = 0;
    int bad   = 0;

    logic [31:0] e_res, e_rs2, e_tgt;
    logic        e_taken;
    int          e_lat;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                (clk),
        .rstn               (rstn),
        .i_ex_pc_current    (pc),
        .i_ex_immediate     (imm),
        .i_ex_alu_din_a_sel (asel),
        .i_ex_alu_din_b_sel (bsel),
        .i_ex_alu_func      (func),
        .i_ex_bu_func       (bu),
        .i_ex_opcode        (opc),
        .i_ex_rf_dout_rs1   (rf1),
        .i_ex_rf_dout_rs2   (rf2),
        .i_ex_rf_raddr_rs1  (ra1),
        .i_ex_rf_raddr_rs2  (ra2),
        .i_mem_rf_we        (mwe),
        .i_mem_rf_waddr     (mwa),
        .i_mem_fwd_data     (mfd),
        .i_wb_rf_we         (wwe),
        .i_wb_rf_waddr      (wwa),
        .i_wb_rf_din        (wdin),
        .o_ex_alu_result    (res),
        .o_ex_rs2_fwd       (rs2f),
        .o_ex_valid         (valid),
        .o_ex_busy          (busy),
        .o_ex_branch_taken  (taken),
        .o_ex_branch_target (tgt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] ra, input logic [31:0] rf);
        if (ra != 0 && mwe && mwa == ra) return mfd;
        if (ra != 0 && wwe && wwa == ra) return wdin;
        return rf;
    endfunction

    task automatic model();
        logic [31:0] x1, x2, a, b;
        int sh;
        x1 = operand(ra1, rf1);
        x2 = operand(ra2, rf2);
        a  = asel ? pc : x1;
        b  = bsel ? imm : x2;
        sh = int'(b % 32);
        e_rs2 = x2;
        e_lat = 0;
        case (func)
            0: e_res = a + b;
            1: e_res = a - b;
            2: e_res = a << sh;
            3: e_res = ($signed(a) < $signed(b)) ? 1 : 0;
            4: e_res = (a < b) ? 1 : 0;
            5: e_res = a ^ b;
            6: e_res = a >> sh;
            7: e_res = $unsigned($signed(a) >>> sh);
            8: e_res = a | b;
            9: e_res = a & b;
            10: e_res = b;
            default: e_res = 0;
        endcase
`ifndef EX_FAST_SHIFT_EN
        if (func == 2 || func == 6 || func == 7) e_lat = sh;
`endif
        e_tgt = pc + imm;
        e_taken = 0;
        if (opc == 7'h63) begin
            case (bu)
                0: e_taken = (x1 == x2);
                1: e_taken = (x1 != x2);
                4: e_taken = ($signed(x1) < $signed(x2));
                5: e_taken = ($signed(x1) >= $signed(x2));
                6: e_taken = (x1 < x2);
                7: e_taken = (x1 >= x2);
                default: e_taken = 0;
            endcase
        end else if (opc == 7'h6f) begin
            e_taken = 1;
        end else if (opc == 7'h67) begin
            e_taken = 1;
            e_tgt = (x1 + imm) & 32'hFFFFFFFE;
        end
    endtask

    // Inputs already applied at a negedge; walks the instruction through to completion.
    task automatic run_txn(input string tag);
        model();
        #1;
        if (e_lat == 0) begin
            check({tag, ".res"}, res, e_res);
            check({tag, ".valid"}, {31'd0, valid}, 1);
            check({tag, ".busy"}, {31'd0, busy}, 0);
            check({tag, ".taken"}, {31'd0, taken}, {31'd0, e_taken});
            if (e_taken) check({tag, ".tgt"}, tgt, e_tgt);
            check({tag, ".rs2"}, rs2f, e_rs2);
        end else begin
            for (int k = 0; k <= e_lat; k++) begin
                check({tag, ".busy"}, {31'd0, busy}, 1);
                check({tag, ".nvalid"}, {31'd0, valid}, 0);
                if (k == 0) check({tag, ".ntaken"}, {31'd0, taken}, 0);
                @(negedge clk);
                // Operands were latched at entry, so disturbing the sources must not matter.
                rf1 = $urandom; mfd = $urandom; wdin = $urandom; pc = $urandom;
                #1;
            end
            check({tag, ".sres"}, res, e_res);
            check({tag, ".svalid"}, {31'd0, valid}, 1);
            check({tag, ".sbusy"}, {31'd0, busy}, 0);
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc = 0; imm = 0; rf1 = 0; rf2 = 0; mfd = 0; wdin = 0;
        asel = 0; bsel = 0; mwe = 0; wwe = 0; func = 0; bu = 0; opc = 0;
        ra1 = 0; ra2 = 0; mwa = 0; wwa = 0;
    endtask

    task automatic randomize_inputs();
        logic [6:0] opcs [5];
        opcs[0] = 7'h63; opcs[1] = 7'h6f; opcs[2] = 7'h67; opcs[3] = 7'h33; opcs[4] = 7'h13;
        pc = $urandom; imm = $urandom; rf1 = $urandom; rf2 = $urandom;
        mfd = $urandom; wdin = $urandom;
        if ($urandom_range(0, 3) == 0) rf2 = rf1;
        asel = 1'($urandom); bsel = 1'($urandom); mwe = 1'($urandom); wwe = 1'($urandom);
        func = 4'($urandom_range(0, 15)); bu = 3'($urandom);
        opc = opcs[$urandom_range(0, 4)];
        ra1 = 5'($urandom_range(0, 3)); ra2 = 5'($urandom_range(0, 3));
        mwa = 5'($urandom_range(0, 3)); wwa = 5'($urandom_range(0, 3));
    endtask

    initial begin
        clear_inputs();
        rstn = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.busy", {31'd0, busy}, 0);
        check("rst.valid", {31'd0, valid}, 1);
        check("rst.res", res, 0);
        check("rst.taken", {31'd0, taken}, 0);
        @(negedge clk);
        rstn = 1;

        // MEM beats WB on x5
        clear_inputs();
        ra1 = 5; mwe = 1; mwa = 5; mfd = 7; wwe = 1; wwa = 5; wdin = 9; imm = 3; bsel = 1;
        run_txn("fwd_mem");
        // x0 is never forwarded
        clear_inputs();
        mwe = 1; mwa = 0; mfd = 32'h55; func = 10;
        run_txn("fwd_x0");
        check("fwd_x0.direct", e_res, 0);
        // SRA by 4
        clear_inputs();
        rf1 = 32'h80000000; bsel = 1; imm = 4; func = 7;
        run_txn("sra4");
        check("sra4.model", e_res, 32'hF8000000);
        // BLTU taken, BLT not
        clear_inputs();
        rf1 = 1; rf2 = 32'hFFFFFFFF; ra1 = 1; ra2 = 2; pc = 32'h100; imm = 32'h20; opc = 7'h63; bu = 6;
        run_txn("bltu");
        rf1 = 1; rf2 = 32'hFFFFFFFF; pc = 32'h100; bu = 4;
        run_txn("blt");
        // JALR clears bit 0
        clear_inputs();
        rf1 = 32'h1003; ra1 = 1; imm = 2; opc = 7'h67;
        run_txn("jalr");
        // shifts by 0 and 31
        clear_inputs();
        rf1 = 32'h12345678; func = 2;
        run_txn("sll0");
        rf1 = 32'h80000001; bsel = 1; imm = 31; func = 6;
        run_txn("srl31");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            run_txn($sformatf("rnd%0d", i));
        end

`ifndef EX_FAST_SHIFT_EN
        // Reset in the middle of a 20-bit shift
        clear_inputs();
        rf1 = 32'hDEADBEEF; bsel = 1; imm = 20; func = 2;
        for (int k = 0; k < 5; k++) @(negedge clk);
        #1;
        check("rstmid.busy_before", {31'd0, busy}, 1);
        rstn = 0;
        @(negedge clk);
        #1;
        check("rstmid.busy_in_rst", {31'd0, busy}, 0);
        rstn = 1;
        clear_inputs();
        rf1 = 40; rf2 = 2;
        run_txn("rstmid.add");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
